// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, ALU select codes,
// FSM states and instruction field positions.
package alu_issue_pkg;

  localparam logic [2:0] OP_LOADI = 3'b000;
  localparam logic [2:0] OP_MOV   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;

  localparam logic [2:0] SEL_PASS = 3'd0;
  localparam logic [2:0] SEL_ADD  = 3'd1;
  localparam logic [2:0] SEL_AND  = 3'd2;
  localparam logic [2:0] SEL_OR   = 3'd3;

  localparam int OPC_LSB  = 24;
  localparam int OPC_W    = 3;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  // ST_HALT is only reachable when the illegal-opcode trap is built in
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: NREG x DATA_W, two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear of every entry.
module alu_issue_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts instructions, drives the combinational ALU and
// writes its result back. Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN halts on illegal opcodes.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREG    = 8,
  parameter int INSTR_W = 32,
  localparam int AW     = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_data1,
  output logic [DATA_W-1:0]  alu_data2,
  output logic [2:0]         alu_select,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               wb_valid,
  output logic [AW-1:0]      wb_dest,
  output logic [DATA_W-1:0]  wb_data,
  output logic               illegal
);

  state_t            state;
  logic [AW-1:0]     dest_q;
  logic              ill_q;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] dec_d1;
  logic [DATA_W-1:0] dec_d2;
  logic [2:0]        dec_sel;
  logic              dec_legal;
  logic              unused_instr;

  assign opcode       = instr[OPC_LSB +: OPC_W];
  assign unused_instr = ^{instr[INSTR_W-1:27], instr[23:19], instr[15:11]};

  // The write lands at the end of the WB cycle, before the next accept can read it
  alu_issue_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .raddr1  (instr[SRC1_LSB +: AW]),
    .raddr2  (instr[SRC2_LSB +: AW]),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .we      (wb_valid),
    .waddr   (wb_dest),
    .wdata   (wb_data)
  );

  // Illegal opcodes leave the ALU operands untouched so Select stays defined
  always_comb begin
    dec_d1    = alu_data1;
    dec_d2    = alu_data2;
    dec_sel   = alu_select;
    dec_legal = 1'b1;
    case (opcode)
      OP_LOADI: begin dec_d1 = instr[SRC2_LSB +: DATA_W]; dec_d2 = '0; dec_sel = SEL_PASS; end
      OP_MOV:   begin dec_d1 = rdata2; dec_d2 = '0;     dec_sel = SEL_PASS; end
      OP_ADD:   begin dec_d1 = rdata1; dec_d2 = rdata2; dec_sel = SEL_ADD;  end
      OP_AND:   begin dec_d1 = rdata1; dec_d2 = rdata2; dec_sel = SEL_AND;  end
      OP_OR:    begin dec_d1 = rdata1; dec_d2 = rdata2; dec_sel = SEL_OR;   end
      default:  dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_select  <= SEL_PASS;
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
      dest_q      <= '0;
      ill_q       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
`ifndef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            alu_data1   <= dec_d1;
            alu_data2   <= dec_d2;
            alu_select  <= dec_sel;
            dest_q      <= instr[DEST_LSB +: AW];
            ill_q       <= !dec_legal;
            instr_ready <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ill_q) begin
            illegal <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            state   <= ST_HALT;
`else
            state   <= ST_WB;
`endif
          end else begin
            wb_valid <= 1'b1;
            wb_dest  <= dest_q;
            wb_data  <= alu_result;
            state    <= ST_WB;
          end
        end
        ST_WB: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
          state       <= ST_HALT;
`else
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: driver queues hand-computed writebacks,
// a monitor compares them whenever wb_valid or a rising illegal appears.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [7:0]  alu_data1, alu_data2, alu_result, wb_data;
  logic [2:0]  alu_select, wb_dest;
  logic        wb_valid, illegal;

  typedef struct {
    bit         ill;
    logic [2:0] dest;
    logic [7:0] data;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
    int         cyc;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_select  (alu_select),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the combinational ALU
  always_comb begin
    case (alu_select)
      3'd0:    alu_result = alu_data1;
      3'd1:    alu_result = alu_data1 + alu_data2;
      3'd2:    alu_result = alu_data1 & alu_data2;
      3'd3:    alu_result = alu_data1 | alu_data2;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [7:0] s2);
    return {5'b0, op, 5'b0, d, 5'b0, s1, s2};
  endfunction

  task automatic apply_stimulus(input logic [31:0] w, input bit push, input bit ill,
                                input logic [2:0] dest, input logic [7:0] data,
                                input logic [7:0] d1, input logic [7:0] d2,
                                input logic [2:0] sel);
    int  guard;
    ev_t e;
    guard       = 0;
    instr_valid = 1'b1;
    instr       = w;
    while (!instr_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_ready", instr_ready, 1);
    if (instr_ready && push) begin
      e.ill  = ill;
      e.dest = dest;
      e.data = data;
      e.d1   = d1;
      e.d2   = d2;
      e.sel  = sel;
      e.cyc  = cyc + 2;
      sbq.push_back(e);
    end
    @(negedge clk);
    check_output("ready_low_exec", instr_ready, 0);
  endtask

  task automatic check_reset_state();
    check_output("rst_ready", instr_ready, 1);
    check_output("rst_wb_valid", wb_valid, 0);
    check_output("rst_wb_dest", wb_dest, 0);
    check_output("rst_wb_data", wb_data, 0);
    check_output("rst_illegal", illegal, 0);
    check_output("rst_alu_data1", alu_data1, 0);
    check_output("rst_alu_data2", alu_data2, 0);
    check_output("rst_alu_select", alu_select, 0);
  endtask

  // Monitor: pops one expected event per writeback or illegal rising edge
  initial begin
    logic ill_prev;
    ill_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && (wb_valid || (illegal && !ill_prev))) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: wb_valid=%0b illegal=%0b dest=%0d data=0x%0h required none",
                   wb_valid, illegal, wb_dest, wb_data);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          check_output("wb_valid", wb_valid, {31'b0, !e.ill});
          check_output("illegal", illegal, {31'b0, e.ill});
          if (!e.ill) begin
            check_output("wb_dest", wb_dest, e.dest);
            check_output("wb_data", wb_data, e.data);
          end
          check_output("alu_data1", alu_data1, e.d1);
          check_output("alu_data2", alu_data2, e.d2);
          check_output("alu_select", alu_select, e.sel);
          check_output("wb_cycle", cyc, e.cyc);
        end
      end
      ill_prev = illegal;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state();

    apply_stimulus(mk(OP_LOADI, 3'd1, 3'd0, 8'h05), 1, 0, 3'd1, 8'h05, 8'h05, 8'h00, 3'd0);
    apply_stimulus(mk(OP_LOADI, 3'd2, 3'd0, 8'h02), 1, 0, 3'd2, 8'h02, 8'h02, 8'h00, 3'd0);
    apply_stimulus(mk(OP_OR,    3'd3, 3'd1, 8'h02), 1, 0, 3'd3, 8'h07, 8'h05, 8'h02, 3'd3);

    apply_stimulus(mk(OP_LOADI, 3'd1, 3'd0, 8'hF0), 1, 0, 3'd1, 8'hF0, 8'hF0, 8'h00, 3'd0);
    apply_stimulus(mk(OP_LOADI, 3'd2, 3'd0, 8'h20), 1, 0, 3'd2, 8'h20, 8'h20, 8'h00, 3'd0);
    apply_stimulus(mk(OP_ADD,   3'd4, 3'd1, 8'h02), 1, 0, 3'd4, 8'h10, 8'hF0, 8'h20, 3'd1);
    apply_stimulus(mk(OP_AND,   3'd5, 3'd1, 8'h02), 1, 0, 3'd5, 8'h20, 8'hF0, 8'h20, 3'd2);
    apply_stimulus(mk(OP_MOV,   3'd6, 3'd0, 8'h03) | 32'hF8F8F800, 1, 0, 3'd6, 8'h07, 8'h07, 8'h00, 3'd0);

    // Back-to-back with instr_valid held high: accepts every third cycle
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    c0 = cyc;
    apply_stimulus(mk(OP_LOADI, 3'd7, 3'd0, 8'h81), 1, 0, 3'd7, 8'h81, 8'h81, 8'h00, 3'd0);
    apply_stimulus(mk(OP_ADD,   3'd0, 3'd7, 8'h06), 1, 0, 3'd0, 8'h88, 8'h81, 8'h07, 3'd1);
    apply_stimulus(mk(OP_OR,    3'd1, 3'd0, 8'h04), 1, 0, 3'd1, 8'h98, 8'h88, 8'h10, 3'd3);
    apply_stimulus(mk(OP_AND,   3'd2, 3'd1, 8'h07), 1, 0, 3'd2, 8'h80, 8'h98, 8'h81, 3'd2);
    check_output("b2b_cycles", cyc - c0, 10);

    apply_stimulus(mk(3'b110, 3'd3, 3'd1, 8'h02), 1, 1, 3'd0, 8'h00, 8'h98, 8'h81, 3'd2);
    instr_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    repeat (4) @(negedge clk);
    check_output("trap_illegal_sticky", illegal, 1);
    check_output("trap_ready_low", instr_ready, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("trap_cleared", illegal, 0);
    check_output("trap_ready_back", instr_ready, 1);
`else
    repeat (2) @(negedge clk);
    check_output("illegal_pulse_end", illegal, 0);
`endif
    apply_stimulus(mk(OP_LOADI, 3'd3, 3'd0, 8'h3C), 1, 0, 3'd3, 8'h3C, 8'h3C, 8'h00, 3'd0);

    // Reset during EXEC aborts the ADD and clears every register
    apply_stimulus(mk(OP_ADD, 3'd5, 3'd1, 8'h02), 0, 0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd0);
    instr_valid = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state();

    apply_stimulus(mk(OP_OR,  3'd3, 3'd1, 8'h02), 1, 0, 3'd3, 8'h00, 8'h00, 8'h00, 3'd3);
    apply_stimulus(mk(OP_MOV, 3'd4, 3'd0, 8'h07), 1, 0, 3'd4, 8'h00, 8'h00, 8'h00, 3'd0);
    apply_stimulus(mk(OP_ADD, 3'd5, 3'd3, 8'h06), 1, 0, 3'd5, 8'h00, 8'h00, 8'h00, 3'd1);

    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_output("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Producer side of the ALU operand/select interface. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 8x8 register file, drives DATA1/DATA2/Select into the combinational ALU, captures the ALU result and writes it back. It sits between the instruction fetch stage and the alu instance in the processor datapath.

Parameters:
DATA_W, 8, operand/result width; must match ALU width
NREG, 8, register file depth; index width is clog2(NREG)=3
INSTR_W, 32, instruction word width

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction word present
instr  input  32  instruction: [26:24] opcode, [18:16] dest, [10:8] src1, [7:0] src2 index ([2:0]) or immediate
instr_ready  output  1  controller can accept an instruction
alu_data1  output  8  ALU DATA1 operand
alu_data2  output  8  ALU DATA2 operand
alu_select  output  3  ALU Select code
alu_result  input  8  ALU out (combinational from the three outputs above)
wb_valid  output  1  one-cycle pulse: register written this cycle
wb_dest  output  3  register index written
wb_data  output  8  value written
illegal  output  1  illegal opcode indication (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert by design of the reset tree): state=IDLE, all 8 registers=0x00, instr_ready=1, alu_data1/alu_data2=0x00, alu_select=3'd0, wb_valid=0, wb_dest=0, wb_data=0, illegal=0. Reset mid-instruction aborts it with no writeback.
- FSM states: IDLE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch the instruction and go to EXEC. Otherwise stay.
- EXEC: instr_ready=0. Registered alu_* outputs hold the decoded operands for the whole cycle. Go to WB.
- WB: instr_ready=0. Capture alu_result into regfile[dest]. Assert wb_valid for exactly this cycle with wb_dest/wb_data. Go to IDLE.
- Throughput: 1 instruction per 3 cycles. Latency: accept edge to wb_valid = 2 cycles.
- Decode (opcode -> data1, data2, select):
  - 000 LOADI: imm, 0, 0
  - 001 MOV: reg[src2[2:0]], 0, 0
  - 010 ADD: reg[src1], reg[src2], 1
  - 011 AND: reg[src1], reg[src2], 2
  - 100 OR: reg[src1], reg[src2], 3
  - 101-111: illegal; no writeback, wb_valid stays 0
- Arithmetic: ADD wraps modulo 256; no carry is exported.
- alu_* outputs hold their last value in IDLE and WB. The ALU is never presented an undefined Select.
- Register reads in EXEC see the value written by the preceding instruction's WB. Strict sequencing means no forwarding is needed.
- Unused instruction bits [31:27], [23:19], [15:11] are ignored.

Optional Feature:
ALU_ISSUE_ILLEGAL_TRAP_EN
- Defined: an illegal opcode sets illegal=1 (sticky) and the FSM enters HALT. instr_ready=0 until reset_n is asserted.
- Undefined: an illegal opcode is a NOP. It takes the normal 3 cycles with no writeback, illegal pulses 1 for the WB cycle only, and operation continues.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode localparams OP_LOADI..OP_OR
  - ALU select encodings SEL_PASS=0, SEL_ADD=1, SEL_AND=2, SEL_OR=3
  - FSM state encoding
  - instruction field bit positions
- One sub-module, alu_issue_regfile: NREG x DATA_W, two async read ports, one sync write port, async active-low clear.

Test Plan:
- Reset, then LOADI r1=0x05 and LOADI r2=0x02 -> wb_valid pulses 2 cycles after each accept; wb_dest=1/wb_data=0x05, then wb_dest=2/wb_data=0x02.
- OR r3=r1|r2 (r1=0x05, r2=0x02) -> EXEC shows alu_select=3, alu_data1=0x05, alu_data2=0x02; WB writes r3=0x07.
- ADD wrap: r1=0xF0, r2=0x20, ADD r4 -> wb_data=0x10. AND of the same operands -> 0x20.
- instr_valid held high continuously with 4 back-to-back instructions -> instr_ready high only in IDLE; exactly 4 wb_valid pulses spaced 3 cycles apart.
- Opcode 3'b110 -> no wb_valid. With ALU_ISSUE_ILLEGAL_TRAP_EN: illegal stays 1 and instr_ready stays 0 until reset. Without it: illegal pulses one cycle and the next LOADI completes normally.
- Assert reset_n low during EXEC of ADD -> no wb_valid, all registers read 0x00, instr_ready=1 after release.
